// File: rtl/fp_pkg.sv
// Shared front-panel definitions: switch channel indices and the
// per-channel conditioner state encoding.
package fp_pkg;

  localparam int SW_CLEAR = 0;
  localparam int SW_EXTD  = 1;
  localparam int SW_ADDR  = 2;
  localparam int SW_DEP   = 3;
  localparam int SW_EXAM  = 4;
  localparam int SW_CONT  = 5;
  localparam int SW_DSEL  = 6;
  localparam int SW_SSTEP = 7;
  localparam int SW_HALT  = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_WAIT = 2'd1,
    ST_ON         = 2'd2,
    ST_REL_WAIT   = 2'd3
  } sw_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sw_chan.sv
// One switch channel: 2-flop synchroniser, debounce FSM, optional auto-repeat.
module sw_chan
  import fp_pkg::*;
#(
  parameter int DEBOUNCE   = 500000,
  parameter bit RPT_EN     = 1'b0,
  parameter int RPT_DELAY  = 25000000,
  parameter int RPT_PERIOD = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic sw_level,
  output logic sw_pulse
);

  localparam int CNT_W = max_int(1, $clog2(DEBOUNCE));
  localparam int RPT_W = max_int(1, $clog2(max_int(RPT_DELAY, RPT_PERIOD)));

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(RPT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_LAST   = RPT_W'(RPT_PERIOD - 1);

  logic             s1;
  logic             s2;
  sw_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_seen;

  // Synchronise the raw input, then debounce and generate press/repeat pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      state    <= ST_IDLE;
      cnt      <= '0;
      rpt_cnt  <= '0;
      rpt_seen <= 1'b0;
      sw_level <= 1'b0;
      sw_pulse <= 1'b0;
    end else begin
      s1       <= sw_raw;
      s2       <= s1;
      sw_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s2) begin
            state <= ST_PRESS_WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        ST_PRESS_WAIT: begin
          if (!s2) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state    <= ST_ON;
            sw_level <= 1'b1;
            sw_pulse <= 1'b1;
            rpt_cnt  <= '0;
            rpt_seen <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ON: begin
          if (!s2) begin
            state <= ST_REL_WAIT;
            cnt   <= CNT_W'(1);
          end else if (RPT_EN) begin
            // rpt_seen selects the initial delay vs. the steady repeat period
            if (rpt_cnt == (rpt_seen ? PER_LAST : DELAY_LAST)) begin
              sw_pulse <= 1'b1;
              rpt_cnt  <= '0;
              rpt_seen <= 1'b1;
            end else begin
              rpt_cnt <= rpt_cnt + 1'b1;
            end
          end
        end
        ST_REL_WAIT: begin
          if (s2) begin
            state    <= ST_ON;
            rpt_cnt  <= '0;
            rpt_seen <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state    <= ST_IDLE;
            sw_level <= 1'b0;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sw_conditioner.sv
// Front-panel switch conditioner: one independent sw_chan per switch plus
// a combined activity flag.
module sw_conditioner
  import fp_pkg::*;
#(
  parameter int              N_SW       = 9,
  parameter int              DEBOUNCE   = 500000,
  parameter logic [N_SW-1:0] RPT_MASK   = 9'b000011000,
  parameter int              RPT_DELAY  = 25000000,
  parameter int              RPT_PERIOD = 5000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_level,
  output logic [N_SW-1:0] sw_pulse,
  output logic            any_active
);

  for (genvar i = 0; i < N_SW; i++) begin : g_chan
    sw_chan #(
      .DEBOUNCE  (DEBOUNCE),
      .RPT_EN    (RPT_MASK[i]),
      .RPT_DELAY (RPT_DELAY),
      .RPT_PERIOD(RPT_PERIOD)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .sw_raw  (sw_raw[i]),
      .sw_level(sw_level[i]),
      .sw_pulse(sw_pulse[i])
    );
  end

  // Busy indication from the registered levels.
  always_comb begin
    any_active = |sw_level;
  end

endmodule
